game_draw_sequencer: RTL and testbench
======================================

GAME_DRAW_SEQUENCER -- requirements
Module: game_draw_sequencer

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4: number of drawing clients, 1..8, served in index order.
REQ-002 SHALL have parameter NUM_PLAYERS, default 2: number of score channels, 2..4.
REQ-003 SHALL have parameter SCORE_W, default 4: per-player score width.
REQ-004 SHALL have parameter WIN_SCORE, default 3: score that ends the match, 1..2^SCORE_W-1.
REQ-005 SHALL have parameters SCREEN_W, default 160, and SCREEN_H, default 120: erase sweep extent.
REQ-006 SHALL have parameter TIMEOUT, default 65535: maximum cycles per client grant.
REQ-007 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports: go  in  1  start match; pause  in  1  hold between clients.
REQ-009 SHALL have ports: client_go  out  NUM_CLIENTS  one-hot grant; client_done  in  NUM_CLIENTS  done pulse.
REQ-010 SHALL have ports: client_x  in  8*NUM_CLIENTS; client_y  in  7*NUM_CLIENTS; client_colour  in  3*NUM_CLIENTS; client_plot  in  NUM_CLIENTS (client i occupies slice i).
REQ-011 SHALL have ports: score_pulse  in  NUM_PLAYERS  one-cycle point-scored strobes.
REQ-012 SHALL have ports: x  out  8; y  out  7; colour  out  3; plot  out  1  (to VGA adapter).
REQ-013 SHALL have ports: scores  out  SCORE_W*NUM_PLAYERS; winner  out  2; game_over  out  1; erasing  out  1; timeout_err  out  1.

Function
REQ-014 SHALL implement states IDLE, ERASE, SERVE, CHECK, OVER.
REQ-015 IDLE: go=1 -> ERASE next cycle, all scores cleared to 0, timeout_err cleared.
REQ-016 ERASE: internal counters sweep x=0..SCREEN_W-1 (inner), y=0..SCREEN_H-1 (outer), one pixel per cycle, colour=0, plot=1, erasing=1; exactly SCREEN_W*SCREEN_H cycles; after the last pixel -> SERVE with client index 0.
REQ-017 SERVE: client_go[idx]=1 (others 0); x/y/colour/plot driven combinationally from slice idx.
REQ-018 Grant SHALL hold until client_done[idx]=1; the following cycle drops client_go[idx] and advances idx; client_done on a non-granted index SHALL be ignored.
REQ-019 After the done of client NUM_CLIENTS-1 -> CHECK (one cycle, plot=0), then SERVE idx 0, or OVER if any score >= WIN_SCORE.
REQ-020 pause=1 SHALL be sampled only at grant boundaries: no new grant is issued while pause=1; an in-progress grant completes normally.
REQ-021 A per-grant cycle counter SHALL force advance after TIMEOUT cycles without done, and set sticky timeout_err=1.
REQ-022 score_pulse[p]=1 SHALL increment score p by 1 in the same clock edge in every state except IDLE and OVER; simultaneous pulses on several players all count.
REQ-023 Scores SHALL saturate at 2^SCORE_W-1, never wrap.
REQ-024 winner = lowest index p with score >= WIN_SCORE, latched on entry to OVER; ties resolve to lowest index.
REQ-025 OVER: game_over=1, no grants, plot=0; go=1 -> ERASE (new match, scores cleared); go held through OVER must not restart twice (edge-detected).
REQ-026 Outside ERASE and SERVE, plot SHALL be 0 and x/y/colour SHALL be 0.

Reset
REQ-027 reset=1 at any clock edge SHALL force IDLE, idx=0, erase counters 0, grant counter 0, all scores 0, winner=0, game_over=0, erasing=0, timeout_err=0, client_go=0, plot=0, regardless of state or mid-grant/mid-erase position.
REQ-028 After reset release, the block SHALL remain in IDLE until a go rising edge.

Verification
REQ-029 go pulse from IDLE -> erasing=1 for exactly 19200 cycles with first pixel (0,0) and last (159,119), colour 0, then client_go=4'b0001.
REQ-030 Clients 0..3 each assert done after 5 cycles -> grants 0001,0010,0100,1000 in order, one CHECK cycle, then 0001 again; plot/x/y mirror the granted client only.
REQ-031 score_pulse=2'b11 in one cycle with scores 2/2, WIN_SCORE=3 -> scores 3/3; at next CHECK -> OVER, game_over=1, winner=0.
REQ-032 Client 2 never asserts done, TIMEOUT=100 -> grant 2 drops after 100 cycles, client 3 granted, timeout_err=1 until next go.
REQ-033 pause=1 during grant 1 -> grant 1 completes, client_go stays 0 while paused, grant 2 issues the cycle after pause=0.
REQ-034 reset=1 mid-ERASE at pixel (80,60) -> next cycle IDLE, plot=0, erasing=0; a later go restarts the sweep at (0,0).

Source files
------------

// File: rtl/game_draw_sequencer.sv
// Match sequencer: clears the screen, then grants the VGA plot port to each drawing client in turn until a player wins.
// Pixel outputs are combinational from the erase counters or the granted client; pause holds off new grants only at grant boundaries.
module game_draw_sequencer #(
    parameter int NUM_CLIENTS = 4,
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 3,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int TIMEOUT     = 65535
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           go,
    input  logic                           pause,
    output logic [NUM_CLIENTS-1:0]         client_go,
    input  logic [NUM_CLIENTS-1:0]         client_done,
    input  logic [8*NUM_CLIENTS-1:0]       client_x,
    input  logic [7*NUM_CLIENTS-1:0]       client_y,
    input  logic [3*NUM_CLIENTS-1:0]       client_colour,
    input  logic [NUM_CLIENTS-1:0]         client_plot,
    input  logic [NUM_PLAYERS-1:0]         score_pulse,
    output logic [7:0]                     x,
    output logic [6:0]                     y,
    output logic [2:0]                     colour,
    output logic                           plot,
    output logic [SCORE_W*NUM_PLAYERS-1:0] scores,
    output logic [1:0]                     winner,
    output logic                           game_over,
    output logic                           erasing,
    output logic                           timeout_err
);
    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         X_LAST    = 8'(SCREEN_W - 1);
    localparam logic [6:0]         Y_LAST    = 7'(SCREEN_H - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_CLIENTS - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ERASE, SERVE, CHECK, OVER} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               active, active_nxt;
    logic [7:0]         ex, ex_nxt;
    logic [6:0]         ey, ey_nxt;
    logic [TO_W-1:0]    gcnt, gcnt_nxt;
    logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
    logic               go_q;
    logic               go_rise;
    logic               clr_match;
    logic               set_to;
    logic               latch_win;
    logic               win_any;
    logic [1:0]         win_idx;
    logic               done_sel;

    assign go_rise = go & ~go_q;

    // Lowest-index player at or above the winning score.
    always_comb begin
        win_any = 1'b0;
        win_idx = 2'd0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (score_q[p] >= WIN_VAL) begin
                win_any = 1'b1;
                win_idx = 2'(p);
            end
        end
    end

    always_comb begin
        done_sel = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (IDX_W'(i) == idx) done_sel = client_done[i];
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        active_nxt = active;
        ex_nxt     = ex;
        ey_nxt     = ey;
        gcnt_nxt   = gcnt;
        clr_match  = 1'b0;
        set_to     = 1'b0;
        latch_win  = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (go_rise) begin
                    state_nxt = ERASE;
                    ex_nxt    = 8'd0;
                    ey_nxt    = 7'd0;
                    clr_match = 1'b1;
                end
            end
            ERASE: begin
                if (ex == X_LAST) begin
                    ex_nxt = 8'd0;
                    if (ey == Y_LAST) begin
                        ey_nxt     = 7'd0;
                        state_nxt  = SERVE;
                        idx_nxt    = '0;
                        active_nxt = ~pause;
                        gcnt_nxt   = '0;
                    end else begin
                        ey_nxt = ey + 7'd1;
                    end
                end else begin
                    ex_nxt = ex + 8'd1;
                end
            end
            SERVE: begin
                // active=0 is the gap between grants where pause is honoured
                if (!active) begin
                    active_nxt = ~pause;
                    gcnt_nxt   = '0;
                end else if (done_sel || gcnt == TO_LAST) begin
                    set_to   = ~done_sel;
                    gcnt_nxt = '0;
                    if (idx == IDX_LAST) begin
                        state_nxt  = CHECK;
                        active_nxt = 1'b0;
                        idx_nxt    = '0;
                    end else begin
                        idx_nxt    = idx + 1'b1;
                        active_nxt = ~pause;
                    end
                end else begin
                    gcnt_nxt = gcnt + 1'b1;
                end
            end
            CHECK: begin
                if (win_any) begin
                    state_nxt = OVER;
                    latch_win = 1'b1;
                end else begin
                    state_nxt  = SERVE;
                    idx_nxt    = '0;
                    active_nxt = ~pause;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            active      <= 1'b0;
            ex          <= 8'd0;
            ey          <= 7'd0;
            gcnt        <= '0;
            winner      <= 2'd0;
            timeout_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            active <= active_nxt;
            ex     <= ex_nxt;
            ey     <= ey_nxt;
            gcnt   <= gcnt_nxt;
            if (latch_win) winner <= win_idx;
            if (clr_match)   timeout_err <= 1'b0;
            else if (set_to) timeout_err <= 1'b1;
        end
    end

    // Free-running so a go held high across reset is not seen as a new edge.
    always_ff @(posedge clk) begin
        go_q <= go;
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (reset || clr_match) begin
                score_q[p] <= '0;
            end else if ((state == ERASE || state == SERVE || state == CHECK) &&
                         score_pulse[p] && score_q[p] != SCORE_MAX) begin
                score_q[p] <= score_q[p] + 1'b1;
            end
        end
    end

    always_comb begin
        client_go = '0;
        x         = 8'd0;
        y         = 7'd0;
        colour    = 3'd0;
        plot      = 1'b0;
        if (state == ERASE) begin
            x    = ex;
            y    = ey;
            plot = 1'b1;
        end else if (state == SERVE && active) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (IDX_W'(i) == idx) begin
                    client_go[i] = 1'b1;
                    x            = client_x[i*8 +: 8];
                    y            = client_y[i*7 +: 7];
                    colour       = client_colour[i*3 +: 3];
                    plot         = client_plot[i];
                end
            end
        end
    end

    always_comb begin
        scores = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            scores[p*SCORE_W +: SCORE_W] = score_q[p];
        end
    end

    assign erasing   = (state == ERASE);
    assign game_over = (state == OVER);

endmodule

// File: tb/tb_game_draw_sequencer.sv
// Directed bench for game_draw_sequencer: vector table for the serve rounds, hand sequences for erase, timeout, win and reset.
module tb_game_draw_sequencer;
    logic        clk = 1'b0;
    logic        reset, go, pause;
    logic [3:0]  client_go, client_done, client_plot;
    logic [31:0] client_x;
    logic [27:0] client_y;
    logic [11:0] client_colour;
    logic [1:0]  score_pulse;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic [7:0]  scores;
    logic [1:0]  winner;
    logic        game_over, erasing, timeout_err;

    logic [3:0]  done_m = 4'b0;
    logic [3:0]  stray  = 4'b0;
    logic [3:0]  en     = 4'b1111;
    int          gcnt_m [4] = '{0, 0, 0, 0};
    int          n_vec = 0;
    int          n_bad = 0;

    assign client_done = done_m | stray;

    game_draw_sequencer #(.TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .go(go), .pause(pause),
        .client_go(client_go), .client_done(client_done),
        .client_x(client_x), .client_y(client_y), .client_colour(client_colour),
        .client_plot(client_plot), .score_pulse(score_pulse),
        .x(x), .y(y), .colour(colour), .plot(plot),
        .scores(scores), .winner(winner), .game_over(game_over),
        .erasing(erasing), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Client model: done pulses on the 5th cycle of its own grant when enabled.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (client_go[i]) begin
                gcnt_m[i]  = gcnt_m[i] + 1;
                done_m[i]  = en[i] && (gcnt_m[i] == 5);
            end else begin
                gcnt_m[i]  = 0;
                done_m[i]  = 1'b0;
            end
        end
    end

    typedef struct {
        int         n;
        logic       pz;
        logic [1:0] sp;
        logic [3:0] st;
        logic [3:0] g;
        logic       p;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        logic [7:0] sc;
    } vec_t;

    function automatic vec_t mk(int n, logic pz, logic [1:0] sp, logic [3:0] st, logic [3:0] g,
                                logic p, logic [7:0] ex, logic [6:0] ey, logic [2:0] ec, logic [7:0] sc);
        vec_t v;
        v.n = n; v.pz = pz; v.sp = sp; v.st = st; v.g = g;
        v.p = p; v.ex = ex; v.ey = ey; v.ec = ec; v.sc = sc;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_go(input logic [3:0] g, input int lim, input string name);
        int t = 0;
        while (client_go !== g && t < lim) begin
            tick;
            t++;
        end
        chk(name, 32'(client_go), 32'(g));
    endtask

    vec_t tbl [19];

    initial begin
        int cnt;
        int t;
        logic [7:0] lx;
        logic [6:0] ly;
        logic bad_px;

        for (int i = 0; i < 4; i++) begin
            client_x[i*8 +: 8]      = 8'(10 + 20*i);
            client_y[i*7 +: 7]      = 7'(5 + 10*i);
            client_colour[i*3 +: 3] = 3'(i + 1);
        end
        client_plot = 4'b1111;

        tbl[0]  = mk(0, 0, 2'b00, 4'b0000, 4'b0001, 1, 10, 5, 1, 8'h00);
        tbl[1]  = mk(4, 0, 2'b00, 4'b0000, 4'b0001, 1, 10, 5, 1, 8'h00);
        tbl[2]  = mk(1, 0, 2'b00, 4'b0000, 4'b0010, 1, 30, 15, 2, 8'h00);
        tbl[3]  = mk(5, 0, 2'b00, 4'b0000, 4'b0100, 1, 50, 25, 3, 8'h00);
        tbl[4]  = mk(5, 0, 2'b00, 4'b0000, 4'b1000, 1, 70, 35, 4, 8'h00);
        tbl[5]  = mk(5, 0, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h00);
        tbl[6]  = mk(1, 0, 2'b00, 4'b0000, 4'b0001, 1, 10, 5, 1, 8'h00);
        tbl[7]  = mk(1, 0, 2'b11, 4'b0000, 4'b0001, 1, 10, 5, 1, 8'h11);
        tbl[8]  = mk(1, 0, 2'b11, 4'b0000, 4'b0001, 1, 10, 5, 1, 8'h22);
        tbl[9]  = mk(1, 0, 2'b00, 4'b1110, 4'b0001, 1, 10, 5, 1, 8'h22);
        tbl[10] = mk(3, 0, 2'b00, 4'b0000, 4'b0010, 1, 30, 15, 2, 8'h22);
        tbl[11] = mk(3, 1, 2'b00, 4'b0000, 4'b0010, 1, 30, 15, 2, 8'h22);
        tbl[12] = mk(1, 1, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h22);
        tbl[13] = mk(3, 1, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h22);
        tbl[14] = mk(1, 0, 2'b00, 4'b0000, 4'b0100, 1, 50, 25, 3, 8'h22);
        tbl[15] = mk(4, 0, 2'b00, 4'b0000, 4'b0100, 1, 50, 25, 3, 8'h22);
        tbl[16] = mk(1, 0, 2'b00, 4'b0000, 4'b1000, 1, 70, 35, 4, 8'h22);
        tbl[17] = mk(5, 0, 2'b00, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h22);
        tbl[18] = mk(1, 0, 2'b00, 4'b0000, 4'b0001, 1, 10, 5, 1, 8'h22);

        reset = 1'b1; go = 1'b0; pause = 1'b0; score_pulse = 2'b00;
        repeat (3) tick;
        chk("reset client_go", 32'(client_go), 0);
        chk("reset plot", 32'(plot), 0);
        chk("reset erasing", 32'(erasing), 0);
        chk("reset game_over", 32'(game_over), 0);
        chk("reset scores", 32'(scores), 0);
        chk("reset winner", 32'(winner), 0);
        chk("reset timeout_err", 32'(timeout_err), 0);
        reset = 1'b0;
        repeat (3) tick;
        chk("idle stays", 32'({erasing, client_go}), 0);

        // Full screen erase.
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("erase first pixel", 32'({erasing, x, y}), 32'({1'b1, 8'd0, 7'd0}));
        cnt = 0; bad_px = 1'b0; lx = 8'd0; ly = 7'd0;
        while (erasing && cnt < 20000) begin
            cnt++;
            lx = x; ly = y;
            if (colour != 3'd0 || !plot) bad_px = 1'b1;
            tick;
        end
        chk("erase cycles", 32'(cnt), 19200);
        chk("erase last pixel", 32'({lx, ly}), 32'({8'd159, 7'd119}));
        chk("erase colour/plot", 32'(bad_px), 0);

        for (int r = 0; r < 19; r++) begin
            pause = tbl[r].pz;
            score_pulse = tbl[r].sp;
            stray = tbl[r].st;
            for (int k = 0; k < tbl[r].n; k++) begin
                tick;
                score_pulse = 2'b00;
                stray = 4'b0000;
            end
            chk($sformatf("row%0d client_go", r), 32'(client_go), 32'(tbl[r].g));
            chk($sformatf("row%0d pixel", r), 32'({plot, x, y, colour}),
                32'({tbl[r].p, tbl[r].ex, tbl[r].ey, tbl[r].ec}));
            chk($sformatf("row%0d scores", r), 32'(scores), 32'(tbl[r].sc));
        end

        // Client 2 never finishes: its grant must be cut at 100 cycles.
        chk("timeout_err before", 32'(timeout_err), 0);
        en[2] = 1'b0;
        wait_go(4'b0100, 200, "reach grant 2");
        cnt = 0;
        while (client_go == 4'b0100 && cnt < 300) begin
            cnt++;
            tick;
        end
        chk("timeout grant length", 32'(cnt), 100);
        chk("after timeout grant", 32'(client_go), 32'(4'b1000));
        chk("timeout_err set", 32'(timeout_err), 1);
        en[2] = 1'b1;

        // Simultaneous points take both players to the winning score; tie goes to player 0.
        wait_go(4'b0001, 200, "reach next round");
        score_pulse = 2'b11;
        tick;
        score_pulse = 2'b00;
        chk("both score", 32'(scores), 32'h33);
        t = 0;
        while (!game_over && t < 200) begin
            tick;
            t++;
        end
        chk("game_over", 32'(game_over), 1);
        chk("winner tie", 32'(winner), 0);
        chk("over outputs", 32'({client_go, plot, x, y}), 0);
        chk("timeout_err sticky", 32'(timeout_err), 1);
        score_pulse = 2'b01;
        tick;
        score_pulse = 2'b00;
        chk("no score in OVER", 32'(scores), 32'h33);

        // New match from OVER, then reset in the middle of the sweep.
        go = 1'b1;
        tick;
        chk("restart erase", 32'({erasing, x, y}), 32'({1'b1, 8'd0, 7'd0}));
        chk("restart cleared", 32'({scores, timeout_err, game_over}), 0);
        t = 0;
        while (!(erasing && x == 8'd80 && y == 7'd60) && t < 20000) begin
            tick;
            t++;
        end
        chk("reach pixel 80,60", 32'({x, y}), 32'({8'd80, 7'd60}));
        reset = 1'b1;
        tick;
        chk("mid-erase reset", 32'({erasing, plot, client_go, game_over}), 0);
        chk("mid-erase reset scores", 32'({scores, winner}), 0);
        reset = 1'b0;
        repeat (5) tick;
        chk("held go ignored", 32'(erasing), 0);
        go = 1'b0;
        tick;
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("sweep restarts at 0,0", 32'({erasing, x, y}), 32'({1'b1, 8'd0, 7'd0}));

        // Saturation of player 1, who then wins alone.
        t = 0;
        while (erasing && t < 20000) begin
            tick;
            t++;
        end
        chk("third match grant 0", 32'(client_go), 32'(4'b0001));
        score_pulse = 2'b10;
        repeat (18) tick;
        score_pulse = 2'b00;
        chk("score saturates", 32'(scores), 32'hF0);
        t = 0;
        while (!game_over && t < 200) begin
            tick;
            t++;
        end
        chk("winner player 1", 32'({game_over, winner}), 32'({1'b1, 2'd1}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
